// File: rtl/univ_shift_reg_194.sv
// Universal 4-mode shift register (74HC194 style): hold, shift R/L, load.
// Optional clock enable port CE via `define UNIV_SHIFT_REG_194_CE_EN.
module univ_shift_reg_194 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
`ifdef UNIV_SHIFT_REG_194_CE_EN
    input  logic             CE,
`endif
    input  logic             CLR,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] D,
    input  logic             SER,
    output logic [WIDTH-1:0] Q
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             ce;

`ifdef UNIV_SHIFT_REG_194_CE_EN
    assign ce = CE;
`else
    assign ce = 1'b1;
`endif

    // Next-state selection; an unknown mode poisons Q in simulation.
    always_comb begin
        q_d = q_q;
        if (ce) begin
            case (S)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = {q_q[WIDTH-2:0], SER};
                MODE_SHL:  q_d = {SER, q_q[WIDTH-1:1]};
                MODE_LOAD: q_d = D;
                default:   q_d = 'x;
            endcase
        end
    end

    // State register; synchronous clear overrides mode and enable.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_univ_shift_reg_194.sv
// Self-checking bench for univ_shift_reg_194: directed plan plus random
// stimulus against an arithmetic reference model.
module tb_univ_shift_reg_194;

    localparam int W = 4;
    localparam int unsigned MASK = (1 << W) - 1;

    logic         CLK = 1'b0;
    logic         CLR;
    logic [1:0]   S;
    logic [W-1:0] D;
    logic         SER;
    logic [W-1:0] Q;
    logic         ce_r;

    int unsigned  model;
    int           pass_cnt = 0;
    int           chk_cnt  = 0;

    always #5 CLK = ~CLK;

    univ_shift_reg_194 #(.WIDTH(W)) dut (
        .CLK (CLK),
`ifdef UNIV_SHIFT_REG_194_CE_EN
        .CE  (ce_r),
`endif
        .CLR (CLR),
        .S   (S),
        .D   (D),
        .SER (SER),
        .Q   (Q)
    );

    task automatic check(input string tag, input logic [W-1:0] got,
                         input logic [W-1:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    function automatic int unsigned ref_next(
        input int unsigned q, input bit clr, input bit ce,
        input int unsigned s, input int unsigned d, input int unsigned ser);
        if (clr) return 0;
        if (!ce) return q;
        case (s)
            1:       return ((q * 2) + ser) & MASK;
            2:       return (q / 2) + ser * (1 << (W - 1));
            3:       return d & MASK;
            default: return q;
        endcase
    endfunction

    // Called at a falling edge: drive, let one rising edge pass, sample.
    task automatic tick(input bit clr, input logic [1:0] s,
                        input logic [W-1:0] d, input bit ser, input bit ce);
        CLR  = clr;
        S    = s;
        D    = d;
        SER  = ser;
        ce_r = ce;
        model = ref_next(model, clr, ce, s, d, ser);
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        CLR = 1'b1; S = 2'b00; D = '0; SER = 1'b0; ce_r = 1'b1;
        model = 0;
        @(negedge CLK);
        tick(1, 2'b00, 4'b0000, 0, 1);
        check("reset", Q, 4'b0000);

        tick(0, 2'b11, 4'b1010, 0, 1);
        check("clr_preload", Q, 4'b1010);
        tick(1, 2'b00, 4'b0000, 0, 1);
        check("clr", Q, 4'b0000);
        tick(0, 2'b00, 4'b1111, 1, 1);
        check("clr_after_hold", Q, 4'b0000);

        tick(0, 2'b11, 4'b1100, 0, 1);
        check("load", Q, 4'b1100);
        for (int i = 0; i < 3; i++) begin
            tick(0, 2'b00, (i % 2 == 0) ? 4'b0011 : 4'b1111, i % 2 == 0, 1);
            check("hold", Q, 4'b1100);
        end

        tick(1, 2'b00, 4'b0000, 0, 1);
        tick(0, 2'b01, 4'b0000, 1, 1); check("shr1", Q, 4'b0001);
        tick(0, 2'b01, 4'b0000, 1, 1); check("shr2", Q, 4'b0011);
        tick(0, 2'b01, 4'b0000, 1, 1); check("shr3", Q, 4'b0111);
        tick(0, 2'b01, 4'b0000, 1, 1); check("shr4", Q, 4'b1111);
        tick(0, 2'b01, 4'b0000, 0, 1); check("shr_ser0", Q, 4'b1110);

        tick(0, 2'b11, 4'b0011, 0, 1); check("shl_load", Q, 4'b0011);
        tick(0, 2'b10, 4'b0000, 0, 1); check("shl1", Q, 4'b0001);
        tick(0, 2'b10, 4'b0000, 0, 1); check("shl2", Q, 4'b0000);
        tick(0, 2'b10, 4'b0000, 1, 1); check("shl_ser1", Q, 4'b1000);

        tick(0, 2'b11, 4'b0011, 0, 1); check("mix_load", Q, 4'b0011);
        tick(0, 2'b01, 4'b0000, 1, 1); check("mix_shr", Q, 4'b0111);
        tick(0, 2'b10, 4'b0000, 0, 1); check("mix_shl", Q, 4'b0011);
        tick(0, 2'b01, 4'b0000, 1, 1); check("mix_shr2", Q, 4'b0111);
        tick(0, 2'b11, 4'b0011, 0, 1); check("mix_load2", Q, 4'b0011);
        tick(1, 2'b11, 4'b1111, 1, 1); check("clr_beats_load", Q, 4'b0000);

`ifdef UNIV_SHIFT_REG_194_CE_EN
        tick(0, 2'b11, 4'b0101, 0, 1); check("ce_load", Q, 4'b0101);
        tick(0, 2'b11, 4'b1111, 0, 0); check("ce_hold", Q, 4'b0101);
        tick(1, 2'b11, 4'b1111, 0, 0); check("ce_clr", Q, 4'b0000);
        tick(0, 2'b11, 4'b1111, 0, 1); check("ce_on", Q, 4'b1111);
`endif

        for (int i = 0; i < 400; i++) begin
            bit           r_clr;
            logic [1:0]   r_s;
            logic [W-1:0] r_d;
            bit           r_ser;
            bit           r_ce;
            r_clr = ($urandom_range(0, 15) == 0);
            r_s   = 2'($urandom_range(0, 3));
            r_d   = W'($urandom);
            r_ser = 1'($urandom);
`ifdef UNIV_SHIFT_REG_194_CE_EN
            r_ce  = ($urandom_range(0, 3) != 0);
`else
            r_ce  = 1'b1;
`endif
            tick(r_clr, r_s, r_d, r_ser, r_ce);
            check("random", Q, W'(model));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
